rcpu_datapath: RTL and testbench
================================

// Module: rcpu_datapath
// PURPOSE
//  Executing end of the control-unit command interface: owns PC, A, B, operand-address and overflow registers plus the adder/subtractor.
//  Consumes WEa/WEb/WEpc/CTRLa/CTRLpc/CTRLaddr/RW/CIN strobes and returns INSTR and OVF to the control unit.
//  Drives the external single-port RAM, which has an asynchronous read.
// PARAMETERS
//  DATA_W  8  data/instruction word width; opcode = word[DATA_W-1 -: 3]
//  ADDR_W  5  PC/operand width; operand = word[ADDR_W-1:0]; requires ADDR_W <= DATA_W-3
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  WEa        in   1       write enable, A register
//  WEb        in   1       write enable, B register
//  WEpc       in   1       write enable, PC
//  CTRLa      in   1       A source select: 1 = mem_rdata, 0 = ALU result
//  CTRLpc     in   1       PC source select: 1 = OPR (jump), 0 = PC+1
//  CTRLaddr   in   1       mem_addr select: 1 = OPR, 0 = PC
//  RW         in   1       1 = write A to memory this cycle
//  CIN        in   1       0 = A+B, 1 = A-B (A + ~B + 1)
//  INSTR      out  3       mem_rdata[DATA_W-1 -: 3], combinational
//  OVF        out  1       registered signed-overflow flag
//  mem_addr   out  ADDR_W  RAM address
//  mem_wdata  out  DATA_W  RAM write data, always equals A
//  mem_we     out  1       RAM write strobe
//  mem_rdata  in   DATA_W  RAM read data, valid in the same cycle as mem_addr
//  pc_dbg     out  ADDR_W  current PC, for observation
// BEHAVIOUR
//  Reset (reset==0, asynchronous, effective immediately, including mid-store):
//   - PC, A, B, OPR and OVF are cleared to 0.
//   - mem_we is forced to 0 and mem_addr to 0 combinationally while reset is low.
//  Registers: all update on posedge clk, with zero-cycle latency from the strobes sampled at that edge.
//  PC:
//   - WEpc & CTRLpc: PC <= OPR.
//   - WEpc & ~CTRLpc: PC <= PC+1 modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0 with no flag.
//   - ~WEpc: PC holds (HALT).
//  OPR: captured from mem_rdata[ADDR_W-1:0] when WEpc & ~CTRLpc & ~CTRLaddr (the fetch-advance cycle); otherwise it holds.
//  A:
//   - WEa & CTRLa: A <= mem_rdata.
//   - WEa & ~CTRLa: A <= sum[DATA_W-1:0].
//  B: WEb: B <= mem_rdata.
//  ALU (combinational):
//   - sum = A + (CIN ? ~B : B) + CIN, DATA_W bits; carry-out is discarded.
//   - v = (A[msb] == Bop[msb]) & (sum[msb] != A[msb]), where Bop is the B operand after the CIN inversion.
//  OVF: OVF <= v only on WEa & ~CTRLa. Loads and every other cycle hold OVF, so JMPOVF sees the last arithmetic result.
//  Memory:
//   - mem_addr = CTRLaddr ? OPR : PC.
//   - mem_we = RW & reset.
//   - mem_wdata = A, the pre-edge value.
//  Simultaneous events:
//   - RW & WEa in the same cycle: the old A is written and A updates at the edge.
//   - RW while CTRLaddr==0: the write goes to PC (legal, no check).
//   - WEpc & CTRLaddr: PC updates and OPR holds.
//   - WEa & WEb & CTRLa: both load the same mem_rdata.
//  The block contains no state machine of its own. Sequencing belongs to the control unit, and every strobe combination gives the defined result above.
// CONFIGURATION
//  DP_INSTR_CNT_EN defined:
//   - adds output instr_cnt[15:0], reset 0.
//   - increments on each fetch-advance cycle (same condition as the OPR capture).
//   - saturates at 16'hFFFF.
//  DP_INSTR_CNT_EN undefined: instr_cnt port and counter are absent; all other behaviour is identical.
// TESTING (DATA_W=8, ADDR_W=5)
//  1. Load A=0x2A, PC=0x07, drop reset mid-cycle -> immediately PC=0, A=B=0, OVF=0, mem_addr=0x00, mem_we=0.
//  2. A=0x50, B=0x40, WEa=1, CTRLa=0, CIN=0, one edge -> A=0x90, OVF=1; next cycle WEa=0 -> OVF stays 1.
//  3. A=0x05, B=0x07, CIN=1, WEa=1, CTRLa=0 -> A=0xFE, OVF=0; with A=0x80, B=0x01 -> A=0x7F, OVF=1.
//  4. mem_rdata=0xB3, WEpc=1, CTRLpc=0, CTRLaddr=0 -> INSTR=3'b101, OPR=0x13; then WEpc=1, CTRLpc=1 -> PC=0x13.
//  5. OPR=0x1F, A=0x2A, CTRLaddr=1, RW=1, WEpc=0 -> mem_addr=0x1F, mem_we=1, mem_wdata=0x2A, PC and OPR unchanged.
//  6. PC=0x1F, WEpc=1, CTRLpc=0 -> PC=0x00.
//     With DP_INSTR_CNT_EN: counter preset to 0xFFFE, 3 fetch-advance cycles -> instr_cnt=0xFFFF.
//     Without DP_INSTR_CNT_EN: the module elaborates with no instr_cnt port.

Source files
------------

// File: rtl/rcpu_datapath_if.sv
// Command and memory bus between the rcpu control unit / RAM side (master)
// and the datapath (slave).
//
// Strobe semantics: there is no valid/ready pairing on this bus. Every
// strobe is a level sampled at each rising clock edge and acts in that
// cycle only. INSTR, mem_addr, mem_wdata and mem_we are combinational
// results of the current state and strobes. mem_rdata must be valid in the
// same cycle as mem_addr, because the RAM has an asynchronous read.
interface rcpu_datapath_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              WEa;
  logic              WEb;
  logic              WEpc;
  logic              CTRLa;
  logic              CTRLpc;
  logic              CTRLaddr;
  logic              RW;
  logic              CIN;
  logic [2:0]        INSTR;
  logic              OVF;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Control unit plus RAM: issues strobes and returns read data.
  modport master (
    output WEa, WEb, WEpc, CTRLa, CTRLpc, CTRLaddr, RW, CIN, mem_rdata,
    input  INSTR, OVF, mem_addr, mem_wdata, mem_we
  );

  // Datapath: executes strobes and drives the RAM address/write side.
  modport slave (
    input  WEa, WEb, WEpc, CTRLa, CTRLpc, CTRLaddr, RW, CIN, mem_rdata,
    output INSTR, OVF, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/rcpu_datapath.sv
// rcpu_datapath: executing end of the rcpu control-unit command bus.
// Owns PC, A, B, OPR (operand address) and OVF plus the adder/subtractor.
// There is no FSM here; sequencing belongs to the control unit, and the
// current PC is exposed on pc_dbg for observation.
// Optional feature: define DP_INSTR_CNT_EN to add a saturating 16-bit
// instr_cnt output that counts fetch-advance cycles.
// Requires ADDR_W <= DATA_W-3 (operand field sits below the opcode).
module rcpu_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  rcpu_datapath_if.slave    bus,
  output logic [ADDR_W-1:0] pc_dbg
`ifdef DP_INSTR_CNT_EN
  ,
  output logic [15:0]       instr_cnt
`endif
);

  localparam int MSB = DATA_W - 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] opr;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              ovf;

  logic [DATA_W-1:0] b_op;
  logic [DATA_W-1:0] sum;
  logic              v;
  logic              fetch_adv;
  logic              alu_wr;

  // ALU: A+B, or A-B as A + ~B + 1; carry-out is dropped, signed overflow kept.
  always_comb begin
    b_op = bus.CIN ? ~b : b;
    sum  = a + b_op + {{(DATA_W-1){1'b0}}, bus.CIN};
    v    = (a[MSB] == b_op[MSB]) && (sum[MSB] != a[MSB]);
  end

  // Fetch-advance is the only cycle that captures an operand address.
  assign fetch_adv = bus.WEpc && !bus.CTRLpc && !bus.CTRLaddr;
  assign alu_wr    = bus.WEa && !bus.CTRLa;

  // PC: jump to OPR, increment with silent wrap, or hold (HALT).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
    end else if (bus.WEpc) begin
      if (bus.CTRLpc) pc <= opr;
      else            pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // OPR: operand field of the word being fetched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opr <= '0;
    end else if (fetch_adv) begin
      opr <= bus.mem_rdata[ADDR_W-1:0];
    end
  end

  // A: load from memory or take the ALU result; OVF follows ALU writes only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a   <= '0;
      ovf <= 1'b0;
    end else if (bus.WEa) begin
      if (bus.CTRLa) begin
        a <= bus.mem_rdata;
      end else begin
        a <= sum;
      end
      if (alu_wr) ovf <= v;
    end
  end

  // B: load from memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b <= '0;
    end else if (bus.WEb) begin
      b <= bus.mem_rdata;
    end
  end

`ifdef DP_INSTR_CNT_EN
  // Saturating count of fetch-advance cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_cnt <= '0;
    end else if (fetch_adv && (instr_cnt != 16'hFFFF)) begin
      instr_cnt <= instr_cnt + 16'd1;
    end
  end
`endif

  // Memory side: reset blocks any in-flight store and parks the address at 0.
  always_comb begin
    bus.mem_addr  = reset ? (bus.CTRLaddr ? opr : pc) : '0;
    bus.mem_we    = bus.RW && reset;
    bus.mem_wdata = a;
    bus.INSTR     = bus.mem_rdata[MSB -: 3];
    bus.OVF       = ovf;
  end

  assign pc_dbg = pc;

endmodule

// File: tb/tb_rcpu_datapath.sv
// Directed testbench for rcpu_datapath (DATA_W=8, ADDR_W=5).
module tb_rcpu_datapath;

  logic       clk;
  logic       reset;
  logic [4:0] pc_dbg;
`ifdef DP_INSTR_CNT_EN
  logic [15:0] instr_cnt;
`endif

  rcpu_datapath_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  rcpu_datapath #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .pc_dbg   (pc_dbg)
`ifdef DP_INSTR_CNT_EN
    ,
    .instr_cnt(instr_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic expect_val(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.WEa = 0; bus.WEb = 0; bus.WEpc = 0; bus.CTRLa = 0; bus.CTRLpc = 0;
    bus.CTRLaddr = 0; bus.RW = 0; bus.CIN = 0; bus.mem_rdata = 8'h00;
  endtask

  task automatic load_a(input logic [7:0] v);
    idle(); bus.WEa = 1; bus.CTRLa = 1; bus.CTRLaddr = 1; bus.mem_rdata = v;
    step(); idle();
  endtask

  task automatic load_b(input logic [7:0] v);
    idle(); bus.WEb = 1; bus.CTRLaddr = 1; bus.mem_rdata = v;
    step(); idle();
  endtask

  task automatic alu(input logic cin);
    idle(); bus.WEa = 1; bus.CTRLa = 0; bus.CIN = cin; bus.CTRLaddr = 1;
    step(); idle();
  endtask

  task automatic fetch(input logic [7:0] word);
    idle(); bus.WEpc = 1; bus.mem_rdata = word;
    step(); idle();
  endtask

  task automatic jump();
    idle(); bus.WEpc = 1; bus.CTRLpc = 1; bus.CTRLaddr = 1;
    step(); idle();
  endtask

  // OPR is only visible through mem_addr with CTRLaddr=1.
  task automatic chk_opr(input string tag);
    bus.CTRLaddr = 1; #1;
    chk(tag, 16'(bus.mem_addr));
    bus.CTRLaddr = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    reset = 0;
    bus.RW = 1;
    #3;
    expect_val(16'h0000); chk("rst_pc", 16'(pc_dbg));
    expect_val(16'h0000); chk("rst_we", 16'(bus.mem_we));
    expect_val(16'h0000); chk("rst_addr", 16'(bus.mem_addr));
    expect_val(16'h0000); chk("rst_a", 16'(bus.mem_wdata));
    expect_val(16'h0000); chk("rst_ovf", 16'(bus.OVF));
    @(negedge clk); idle(); reset = 1;
    step();

    // Signed add overflow, then hold across idle and loads.
    load_a(8'h50); load_b(8'h40);
    alu(1'b0);
    expect_val(16'h0090); chk("add_a", 16'(bus.mem_wdata));
    expect_val(16'h0001); chk("add_ovf", 16'(bus.OVF));
    step();
    expect_val(16'h0001); chk("ovf_hold_idle", 16'(bus.OVF));
    load_a(8'h05);
    expect_val(16'h0001); chk("ovf_hold_load", 16'(bus.OVF));

    // Subtraction without and with overflow.
    load_b(8'h07);
    alu(1'b1);
    expect_val(16'h00FE); chk("sub_a", 16'(bus.mem_wdata));
    expect_val(16'h0000); chk("sub_ovf", 16'(bus.OVF));
    load_a(8'h80); load_b(8'h01);
    alu(1'b1);
    expect_val(16'h007F); chk("subv_a", 16'(bus.mem_wdata));
    expect_val(16'h0001); chk("subv_ovf", 16'(bus.OVF));

    // Fetch: opcode decode, operand capture, PC advance, then jump.
    idle(); bus.WEpc = 1; bus.mem_rdata = 8'hB3; #1;
    expect_val(16'h0005); chk("instr", 16'(bus.INSTR));
    expect_val(16'h0000); chk("fetch_addr_pc", 16'(bus.mem_addr));
    step(); idle();
    expect_val(16'h0001); chk("fetch_pc", 16'(pc_dbg));
    expect_val(16'h0013); chk_opr("fetch_opr");
    jump();
    expect_val(16'h0013); chk("jump_pc", 16'(pc_dbg));

    // Store through OPR; PC and OPR unchanged.
    fetch(8'h1F);
    expect_val(16'h0014); chk("fetch2_pc", 16'(pc_dbg));
    load_a(8'h2A);
    idle(); bus.CTRLaddr = 1; bus.RW = 1; #1;
    expect_val(16'h001F); chk("st_addr", 16'(bus.mem_addr));
    expect_val(16'h0001); chk("st_we", 16'(bus.mem_we));
    expect_val(16'h002A); chk("st_wdata", 16'(bus.mem_wdata));
    step(); idle();
    expect_val(16'h0014); chk("st_pc", 16'(pc_dbg));
    expect_val(16'h001F); chk_opr("st_opr");

    // Store and load A together: old A goes out, new A lands at the edge.
    idle(); bus.CTRLaddr = 1; bus.RW = 1; bus.WEa = 1; bus.CTRLa = 1;
    bus.mem_rdata = 8'h66; #1;
    expect_val(16'h002A); chk("rwa_old", 16'(bus.mem_wdata));
    step(); idle();
    expect_val(16'h0066); chk("rwa_new", 16'(bus.mem_wdata));

    // WEpc with CTRLaddr: PC advances, OPR holds.
    idle(); bus.WEpc = 1; bus.CTRLaddr = 1; bus.mem_rdata = 8'h05;
    step(); idle();
    expect_val(16'h0015); chk("pcaddr_pc", 16'(pc_dbg));
    expect_val(16'h001F); chk_opr("pcaddr_opr");

    // PC wrap at 0x1F.
    jump();
    expect_val(16'h001F); chk("wrap_pre", 16'(pc_dbg));
    fetch(8'h00);
    expect_val(16'h0000); chk("wrap_pc", 16'(pc_dbg));

    // Asynchronous reset mid-cycle, during a store.
    fetch(8'h07); jump();
    expect_val(16'h0007); chk("pre_rst_pc", 16'(pc_dbg));
    load_a(8'h50); load_b(8'h40); alu(1'b0);
    load_a(8'h2A); load_b(8'h11);
    @(negedge clk);
    bus.RW = 1; bus.CTRLaddr = 1;
    #1;
    expect_val(16'h0001); chk("pre_rst_we", 16'(bus.mem_we));
    expect_val(16'h0001); chk("pre_rst_ovf", 16'(bus.OVF));
    reset = 0;
    #1;
    expect_val(16'h0000); chk("arst_pc", 16'(pc_dbg));
    expect_val(16'h0000); chk("arst_a", 16'(bus.mem_wdata));
    expect_val(16'h0000); chk("arst_ovf", 16'(bus.OVF));
    expect_val(16'h0000); chk("arst_we", 16'(bus.mem_we));
    expect_val(16'h0000); chk("arst_addr", 16'(bus.mem_addr));
    @(negedge clk); idle(); reset = 1;
    #1;
    expect_val(16'h0000); chk_opr("arst_opr");
    load_a(8'h01); alu(1'b0);
    expect_val(16'h0001); chk("arst_b", 16'(bus.mem_wdata));

`ifdef DP_INSTR_CNT_EN
    // Counter: cleared by reset, then driven to saturation.
    expect_val(16'h0000); chk("cnt_rst", instr_cnt);
    for (int i = 0; i < 65534; i++) fetch(8'h00);
    expect_val(16'hFFFE); chk("cnt_fffe", instr_cnt);
    for (int i = 0; i < 3; i++) fetch(8'h00);
    expect_val(16'hFFFF); chk("cnt_sat", instr_cnt);
`endif

    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $error("FAIL leftover observed=%0d expected=0", exp_q.size());
    end

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
